tdm_demux_1to4_b4: RTL and testbench

TDM_DEMUX_1TO4_B4 -- requirements
Module: tdm_demux_1to4_b4

---
 rtl/tdm_demux_1to4_b4_pkg.sv | 19 +
 rtl/tdm_demux_1to4_b4_decoder2to4.sv | 16 +
 rtl/tdm_demux_1to4_b4.sv | 124 ++++++++++++
 tb/tb_tdm_demux_1to4_b4.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_1to4_b4_pkg.sv
// Shared definitions for the 1-to-4 TDM demultiplexer: FSM state encoding
// and the default slot width. Guarded so repeated inclusion is harmless.
`ifndef TDM_DEMUX_1TO4_B4_PKG_SV
`define TDM_DEMUX_1TO4_B4_PKG_SV

package tdm_demux_1to4_b4_pkg;

   // Framing state: HUNT waits for a sync beat, ALIGNED collects slots.
   typedef enum logic {
      HUNT    = 1'b0,
      ALIGNED = 1'b1
   } state_e;

   localparam int WIDTH_DEFAULT = 4;
   localparam int SLOTS_FIXED   = 4;

endpackage

`endif

// File: rtl/tdm_demux_1to4_b4_decoder2to4.sv
// 2-to-4 one-hot decoder producing the staging/frame write enables.
module decoder2to4 (
   input  logic [1:0] slot,
   input  logic       en,
   output logic [3:0] onehot
);

   // One enable per slot, all low when en is low.
   always_comb begin
      onehot       = 4'b0000;
      if (en) begin
         onehot[slot] = 1'b1;
      end
   end

endmodule

// File: rtl/tdm_demux_1to4_b4.sv
// 1-to-4 TDM demultiplexer. Serial slot beats are staged until a frame of
// four completes; the frame is then published on O0..O3 with a one-cycle
// frame_valid pulse. A sync beat marks slot 0 and (re)aligns the framer.
// Handshake: a beat is consumed on every rising edge where in_valid=1;
// there is no back-pressure, so in_valid=0 simply freezes all state.
module tdm_demux_1to4_b4
   import tdm_demux_1to4_b4_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int SLOTS = SLOTS_FIXED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             sync,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] O0,
   output logic [WIDTH-1:0] O1,
   output logic [WIDTH-1:0] O2,
   output logic [WIDTH-1:0] O3,
   output logic             frame_valid,
   output logic [1:0]       slot,
   output logic             aligned,
   output logic             sync_err
);

   if (SLOTS != 4) begin : g_slots_check
      $error("tdm_demux_1to4_b4 only supports SLOTS=4");
   end

   state_e           state_q, state_d;
   logic [1:0]       slot_q, slot_d;
   logic [WIDTH-1:0] staging_q [3];
   logic [WIDTH-1:0] staging_d [3];
   logic [WIDTH-1:0] out_q [4];
   logic [WIDTH-1:0] out_d [4];
   logic             frame_valid_q, frame_valid_d;
   logic             sync_err_q, sync_err_d;

   logic [1:0]       dec_slot;
   logic             dec_en;
   logic [3:0]       we;

   // A sync beat always lands in slot 0; otherwise beats are only kept once aligned.
   always_comb begin
      dec_slot = sync ? 2'd0 : slot_q;
      dec_en   = in_valid && (sync || (state_q == ALIGNED));
   end

   decoder2to4 u_dec (
      .slot   (dec_slot),
      .en     (dec_en),
      .onehot (we)
   );

   // Next-state, staging writes and frame publication.
   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      staging_d     = staging_q;
      out_d         = out_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (we[i]) begin
            staging_d[i] = din;
         end
      end
      if (in_valid) begin
         if (sync) begin
            // Restart framing; a sync mid-frame drops the partial frame.
            sync_err_d = (state_q == ALIGNED) && (slot_q != 2'd0);
            state_d    = ALIGNED;
            slot_d     = 2'd1;
         end else if (state_q == ALIGNED) begin
            slot_d = slot_q + 2'd1;
            if (we[3]) begin
               // Slot 3 completes the frame; it goes straight from din.
               out_d[0]      = staging_q[0];
               out_d[1]      = staging_q[1];
               out_d[2]      = staging_q[2];
               out_d[3]      = din;
               frame_valid_d = 1'b1;
            end
         end
      end
   end

   // State registers with synchronous reset taking priority over any beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= HUNT;
         slot_q        <= 2'd0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            staging_q[i] <= '0;
         end
         for (int i = 0; i < 4; i++) begin
            out_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
         staging_q     <= staging_d;
         out_q         <= out_d;
      end
   end

   // All outputs come straight from registers.
   always_comb begin
      O0          = out_q[0];
      O1          = out_q[1];
      O2          = out_q[2];
      O3          = out_q[3];
      frame_valid = frame_valid_q;
      slot        = slot_q;
      aligned     = (state_q == ALIGNED);
      sync_err    = sync_err_q;
   end

endmodule

// File: tb/tb_tdm_demux_1to4_b4.sv
// Bench for tdm_demux_1to4_b4: directed framing scenarios followed by random
// beats, all compared every cycle against a queue-based frame model.
module tb_tdm_demux_1to4_b4;

   localparam int W = 4;

   // Clock and DUT signals
   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         sync;
   logic [W-1:0] din;
   logic [W-1:0] o0, o1, o2, o3;
   logic         frame_valid;
   logic [1:0]   slot;
   logic         aligned;
   logic         sync_err;

   always #5 clk = ~clk;

   tdm_demux_1to4_b4 #(.WIDTH(W), .SLOTS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .sync        (sync),
      .din         (din),
      .O0          (o0),
      .O1          (o1),
      .O2          (o2),
      .O3          (o3),
      .frame_valid (frame_valid),
      .slot        (slot),
      .aligned     (aligned),
      .sync_err    (sync_err)
   );

   // Reference model: the beats of the frame in progress, the last frame.
   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_out [4];
   bit           m_aligned;
   bit           m_fv;
   bit           m_err;

   int n_checks = 0;
   int n_pass   = 0;
   int fv_count = 0;
   int err_count = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (r) begin
         exp_q.delete();
         m_aligned = 1'b0;
         for (int i = 0; i < 4; i++) m_out[i] = '0;
      end else if (v) begin
         if (s) begin
            m_err = m_aligned && (exp_q.size() != 0);
            exp_q.delete();
            exp_q.push_back(d);
            m_aligned = 1'b1;
         end else if (m_aligned) begin
            exp_q.push_back(d);
            if (exp_q.size() == 4) begin
               for (int i = 0; i < 4; i++) m_out[i] = exp_q[i];
               exp_q.delete();
               m_fv = 1'b1;
            end
         end
      end
   endtask

   task automatic check_all();
      check("O0", 32'(o0), 32'(m_out[0]));
      check("O1", 32'(o1), 32'(m_out[1]));
      check("O2", 32'(o2), 32'(m_out[2]));
      check("O3", 32'(o3), 32'(m_out[3]));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("slot", 32'(slot), 32'(exp_q.size()));
      check("aligned", 32'(aligned), 32'(m_aligned));
      check("sync_err", 32'(sync_err), 32'(m_err));
      if (frame_valid) fv_count++;
      if (sync_err) err_count++;
   endtask

   // Driver: apply one cycle of inputs, advance, then compare after the edge.
   task automatic beat(input bit r, input bit v, input bit s, input logic [W-1:0] d);
      rst = r; in_valid = v; sync = s; din = d;
      @(posedge clk);
      model_step(r, v, s, d);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      beat(1'b1, 1'b0, 1'b0, '0);
      beat(1'b1, 1'b1, 1'b1, 4'hF);   // reset wins over a valid sync beat
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0, $urandom_range(0, 1), W'($urandom));
   endtask

   task automatic frame(input logic [W-1:0] a, b, c, d);
      beat(1'b0, 1'b1, 1'b1, a);
      beat(1'b0, 1'b1, 1'b0, b);
      beat(1'b0, 1'b1, 1'b0, c);
      beat(1'b0, 1'b1, 1'b0, d);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; sync = 1'b0; din = '0;
      m_aligned = 1'b0;
      for (int i = 0; i < 4; i++) m_out[i] = '0;

      // Basic frame A,B,C,D
      do_reset();
      frame(4'hA, 4'hB, 4'hC, 4'hD);
      idle(1);
      check("basic_O", {o0, o1, o2, o3}, 16'hABCD);
      check("basic_aligned", 32'(aligned), 32'd1);

      // Unsynced beats in HUNT are dropped
      do_reset();
      beat(1'b0, 1'b1, 1'b0, 4'h5);
      beat(1'b0, 1'b1, 1'b0, 4'h6);
      frame(4'h1, 4'h2, 4'h3, 4'h4);
      check("hunt_O", {o0, o1, o2, o3}, 16'h1234);

      // Mid-frame resync
      do_reset();
      frame(4'h1, 4'h2, 4'h3, 4'h4);
      err_count = 0;
      beat(1'b0, 1'b1, 1'b1, 4'h9);
      beat(1'b0, 1'b1, 1'b0, 4'h8);
      beat(1'b0, 1'b1, 1'b1, 4'h7);
      check("resync_keep_O", {o0, o1, o2, o3}, 16'h1234);
      beat(1'b0, 1'b1, 1'b0, 4'h6);
      beat(1'b0, 1'b1, 1'b0, 4'h5);
      beat(1'b0, 1'b1, 1'b0, 4'h4);
      check("resync_O", {o0, o1, o2, o3}, 16'h7654);
      check("resync_err_count", err_count, 1);

      // Gaps between beats
      do_reset();
      beat(1'b0, 1'b1, 1'b1, 4'hA); idle(3);
      beat(1'b0, 1'b1, 1'b0, 4'hB); idle(3);
      beat(1'b0, 1'b1, 1'b0, 4'hC); idle(3);
      beat(1'b0, 1'b1, 1'b0, 4'hD); idle(3);
      check("gap_O", {o0, o1, o2, o3}, 16'hABCD);

      // Reset mid-frame, then a clean frame
      do_reset();
      fv_count = 0;
      beat(1'b0, 1'b1, 1'b1, 4'h3);
      beat(1'b0, 1'b1, 1'b0, 4'h2);
      beat(1'b0, 1'b1, 1'b0, 4'h1);
      beat(1'b1, 1'b1, 1'b0, 4'h0);
      idle(2);
      check("rst_mid_fv", fv_count, 0);
      frame(4'hE, 4'hF, 4'h0, 4'h1);
      check("rst_mid_O", {o0, o1, o2, o3}, 16'hEF01);

      // Continuous frames, sync only on the first
      do_reset();
      fv_count = 0;
      beat(1'b0, 1'b1, 1'b1, 4'h0);
      for (int i = 1; i < 8; i++) begin
         beat(1'b0, 1'b1, 1'b0, W'(i));
         if (i == 3) check("b2b_first_O", {o0, o1, o2, o3}, 16'h0123);
      end
      check("b2b_second_O", {o0, o1, o2, o3}, 16'h4567);
      check("b2b_fv_count", fv_count, 2);

      // Randomized beats against the model
      for (int i = 0; i < 600; i++) begin
         beat(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) < 2), W'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
